data_mux_core: RTL and testbench

DATA_MUX_CORE -- requirements
Module: data_mux

---
 rtl/data_mux_core.sv | 139 +++++++++++++
 tb/tb_data_mux_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mux_core.sv
// Three-stream symbol-synchronous multiplexer: captures DS1..DS3 on each symbol_clk rise and
// emits one fixed stream or a timed round-robin. Optional macro DATA_MUX_SYNC_EN adds a 2-flop synchronizer.
module data_mux_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              symbol_clk,
    input  logic [CNT_W-1:0]  switch_clk_cycles,
    input  logic [DATA_W-1:0] DS1,
    input  logic [DATA_W-1:0] DS2,
    input  logic [DATA_W-1:0] DS3,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] mux_data,
    output logic [1:0]        mux_sel
);

    localparam logic [1:0] SLOT_0  = 2'd0;
    localparam logic [1:0] SLOT_1  = 2'd1;
    localparam logic [1:0] SLOT_2  = 2'd2;
    localparam logic [1:0] MODE_RR = 2'd3;

    logic              sym_sync;
    logic              sym_prev;
    logic              sym_rise_c;

    logic [DATA_W-1:0] h1_q, h2_q, h3_q;
    logic [DATA_W-1:0] h1_nxt, h2_nxt, h3_nxt;
    logic [1:0]        slot_q, slot_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              rr_active_q;
    logic [CNT_W-1:0]  slot_len_c;
    logic              slot_last_c;
    logic [DATA_W-1:0] hold_sel_c;

`ifdef DATA_MUX_SYNC_EN
    logic sym_meta;

    // Two-flop synchronizer for the asynchronous strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_meta <= 1'b0;
            sym_sync <= 1'b0;
        end else begin
            sym_meta <= symbol_clk;
            sym_sync <= sym_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_sync <= 1'b0;
        end else begin
            sym_sync <= symbol_clk;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_prev <= 1'b0;
        end else begin
            sym_prev <= sym_sync;
        end
    end

    assign sym_rise_c  = sym_sync & ~sym_prev;
    assign slot_len_c  = (switch_clk_cycles == '0) ? CNT_W'(1) : switch_clk_cycles;
    // >= rather than == so a shrinking slot length still ends the current slot
    assign slot_last_c = (cnt_q >= (slot_len_c - CNT_W'(1)));

    // Next-state: capture has priority over rotation; fixed modes pin the slot
    always_comb begin
        h1_nxt   = h1_q;
        h2_nxt   = h2_q;
        h3_nxt   = h3_q;
        slot_nxt = slot_q;
        cnt_nxt  = cnt_q;

        if (sym_rise_c) begin
            h1_nxt = DS1;
            h2_nxt = DS2;
            h3_nxt = DS3;
        end

        if (mode != MODE_RR) begin
            slot_nxt = mode;
            cnt_nxt  = '0;
        end else if (sym_rise_c || !rr_active_q) begin
            slot_nxt = SLOT_0;
            cnt_nxt  = '0;
        end else if (slot_last_c) begin
            cnt_nxt  = '0;
            slot_nxt = (slot_q == SLOT_2) ? SLOT_0 : slot_q + 2'd1;
        end else begin
            cnt_nxt  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            slot_q      <= SLOT_0;
            cnt_q       <= '0;
            rr_active_q <= 1'b0;
        end else begin
            h1_q        <= h1_nxt;
            h2_q        <= h2_nxt;
            h3_q        <= h3_nxt;
            slot_q      <= slot_nxt;
            cnt_q       <= cnt_nxt;
            rr_active_q <= (mode == MODE_RR);
        end
    end

    always_comb begin
        hold_sel_c = h1_q;
        case (slot_q)
            SLOT_1:  hold_sel_c = h2_q;
            SLOT_2:  hold_sel_c = h3_q;
            default: hold_sel_c = h1_q;
        endcase
    end

    // Output stage trails the holding/slot registers by one clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_data <= '0;
            mux_sel  <= SLOT_0;
        end else begin
            mux_data <= hold_sel_c;
            mux_sel  <= slot_q;
        end
    end

endmodule

// File: tb/tb_data_mux_core.sv
// Self-checking bench for data_mux_core: directed vector table, corner sequences and
// randomized traffic compared against a cycle reference model.
module tb_data_mux_core;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
`ifdef DATA_MUX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk;
    logic              rst_n;
    logic              symbol_clk;
    logic [CNT_W-1:0]  switch_clk_cycles;
    logic [DATA_W-1:0] DS1, DS2, DS3;
    logic [1:0]        mode;
    logic [DATA_W-1:0] mux_data;
    logic [1:0]        mux_sel;

    data_mux_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .symbol_clk       (symbol_clk),
        .switch_clk_cycles(switch_clk_cycles),
        .DS1              (DS1),
        .DS2              (DS2),
        .DS3              (DS3),
        .mode             (mode),
        .mux_data         (mux_data),
        .mux_sel          (mux_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mh[3];
    int mslot, mcnt;
    bit was_rr;
    bit hist[4];
    int md, ms;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] sw;
        int         exp_data;
        int         exp_sel;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mh[k] = 0;
        mslot  = 0;
        mcnt   = 0;
        was_rr = 0;
        for (int k = 0; k < 4; k++) hist[k] = 0;
    endtask

    // One clk edge of the model, using the inputs held across that edge
    task automatic model_edge();
        bit rise;
        int len;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = symbol_clk;
        rise = hist[LAT-1] && !hist[LAT];
        md = mh[mslot];
        ms = mslot;
        len = (switch_clk_cycles == 0) ? 1 : int'(switch_clk_cycles);
        if (rise) begin
            mh[0] = int'(DS1);
            mh[1] = int'(DS2);
            mh[2] = int'(DS3);
        end
        if (mode != 2'd3) begin
            mslot = int'(mode);
            mcnt  = 0;
        end else if (rise || !was_rr) begin
            mslot = 0;
            mcnt  = 0;
        end else begin
            mcnt++;
            if (mcnt >= len) begin
                mcnt  = 0;
                mslot = (mslot + 1) % 3;
            end
        end
        was_rr = (mode == 2'd3);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_data", int'(mux_data), md);
        check("model_sel", int'(mux_sel), ms);
    endtask

    task automatic capture(input int a, input int b, input int c);
        symbol_clk = 1'b0;
        repeat (LAT + 1) step();
        DS1 = DATA_W'(a);
        DS2 = DATA_W'(b);
        DS3 = DATA_W'(c);
        symbol_clk = 1'b1;
        repeat (LAT) step();
        symbol_clk = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        symbol_clk = 1'b0;
        switch_clk_cycles = '0;
        DS1 = '0; DS2 = '0; DS3 = '0;
        mode = 2'd0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_data", int'(mux_data), 0);
        check("reset_sel", int'(mux_sel), 0);

        // Strobe already high when reset releases: first sample is a rise
        symbol_clk = 1'b1;
        DS1 = 8'd77; DS2 = 8'd5; DS3 = 8'd9;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (mux_data == 8'd77) break;
        end
        check("rise_to_capture_edges", n - 1, LAT);

        // Round-robin, zero slot length, fixed mode, re-entry into rotation
        mode = 2'd3;
        switch_clk_cycles = 3'd2;
        capture(3, 50, 98);
        DS1 = 8'd200; DS2 = 8'd201; DS3 = 8'd202;
        tbl = '{
            '{2'd3, 3'd2, 3, 0},  '{2'd3, 3'd2, 3, 0},  '{2'd3, 3'd2, 50, 1}, '{2'd3, 3'd2, 50, 1},
            '{2'd3, 3'd2, 98, 2}, '{2'd3, 3'd2, 98, 2}, '{2'd3, 3'd2, 3, 0},  '{2'd3, 3'd2, 3, 0},
            '{2'd3, 3'd0, 50, 1}, '{2'd3, 3'd0, 98, 2}, '{2'd3, 3'd0, 3, 0},  '{2'd3, 3'd0, 50, 1},
            '{2'd1, 3'd2, 98, 2}, '{2'd1, 3'd2, 50, 1}, '{2'd1, 3'd2, 50, 1},
            '{2'd3, 3'd2, 50, 1}, '{2'd3, 3'd2, 3, 0},  '{2'd3, 3'd2, 3, 0},  '{2'd3, 3'd2, 50, 1}
        };
        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            switch_clk_cycles = tbl[i].sw;
            step();
            check("tbl_data", int'(mux_data), tbl[i].exp_data);
            check("tbl_sel", int'(mux_sel), tbl[i].exp_sel);
        end

        // New symbol mid-rotation restarts at DS1
        mode = 2'd3;
        switch_clk_cycles = 3'd2;
        capture(6, 53, 100);
        step();
        check("restart_data0", int'(mux_data), 6);
        check("restart_sel0", int'(mux_sel), 0);
        step();
        check("restart_data1", int'(mux_data), 6);
        step();
        check("restart_data2", int'(mux_data), 53);
        check("restart_sel2", int'(mux_sel), 1);

        // Asynchronous reset mid-cycle
        step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data", int'(mux_data), 0);
        check("async_rst_sel", int'(mux_sel), 0);
        model_reset();
        symbol_clk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) < 2) mode = 2'($urandom_range(2));
            else if ($urandom_range(7) == 0) mode = 2'd3;
            if ($urandom_range(15) == 0) switch_clk_cycles = CNT_W'($urandom);
            DS1 = DATA_W'($urandom);
            DS2 = DATA_W'($urandom);
            DS3 = DATA_W'($urandom);
            if ($urandom_range(5) == 0) symbol_clk = ~symbol_clk;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
